// File: rtl/nv_nvdla_cdma_wt_lock_arb_pkg.sv
// ---------------------------------------------------------------------------
// nv_nvdla_cdma_wt_arb_pkg
// Shared definitions for the CDMA weight-fetch lock arbiter.
//   arb_state_e : arbiter state encoding (idle / locked on an owner)
//   clog2_f     : ceiling log2, used for elaboration-time width checks
// ---------------------------------------------------------------------------
package nv_nvdla_cdma_wt_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/nv_nvdla_cdma_wt_lock_arb_if.sv
// ---------------------------------------------------------------------------
// nv_nvdla_cdma_wt_lock_arb_if
// Request/grant bundle between weight request sources and the arbiter.
//   req        : per-requester request
//   req_last   : qualifies req, the beat ends that requester's burst
//   gnt_busy   : downstream stall, blocks every grant while high
//   gnt        : one-hot grant, a beat is accepted in the same cycle
//   gnt_idx    : index of the granted requester, 0 when no grant
//   arb_locked : arbiter is holding the grant for a burst owner
// master = request side, slave = arbiter.
// ---------------------------------------------------------------------------
interface nv_nvdla_cdma_wt_lock_arb_if #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] req_last;
   logic               gnt_busy;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               arb_locked;

   modport master (
      output req, req_last, gnt_busy,
      input  gnt, gnt_idx, arb_locked
   );

   modport slave (
      input  req, req_last, gnt_busy,
      output gnt, gnt_idx, arb_locked
   );
endinterface

// File: rtl/nv_nvdla_cdma_wt_lock_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// nv_nvdla_cdma_wt_rr_pick
// Combinational rotate-priority picker: the first set request at or above
// ptr, wrapping modulo NUM_REQ, wins. With ptr tied to 0 it degenerates to
// a fixed lowest-index-first priority encoder.
//   req     : request vector
//   ptr     : starting (highest priority) index
//   win     : one-hot winner, all zero when no request
//   win_idx : index of the winner, 0 when no request
// ---------------------------------------------------------------------------
module nv_nvdla_cdma_wt_rr_pick
   import nv_nvdla_cdma_wt_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] win,
   output logic [IDX_W-1:0]   win_idx
);

   int               j;
   logic [IDX_W-1:0] jj;
   logic             found;

   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      j       = 0;
      jj      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         jj = IDX_W'(j);
         if (!found && req[jj]) begin
            found   = 1'b1;
            win[jj] = 1'b1;
            win_idx = jj;
         end
      end
   end

endmodule

// File: rtl/nv_nvdla_cdma_wt_lock_arb.sv
// ---------------------------------------------------------------------------
// nv_nvdla_cdma_wt_lock_arb
// N-requester arbiter for CDMA weight-fetch clients with strict-priority or
// round-robin selection and burst locking. The winner of an idle cycle keeps
// the grant until its last beat, until it drops its request, or until
// MAX_BURST beats have been accepted.
//   nvdla_core_clk : core clock
//   nvdla_core_rst : synchronous active-high reset
//   arb            : request/grant bundle (slave side)
// Grants are combinational (zero latency); state, owner, burst count and
// round-robin pointer are registered.
// ---------------------------------------------------------------------------
module nv_nvdla_cdma_wt_lock_arb
   import nv_nvdla_cdma_wt_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int IDX_W     = 2,
   parameter int RR_MODE   = 1,
   parameter int MAX_BURST = 8,
   parameter int CNT_W     = 8
) (
   input  logic                        nvdla_core_clk,
   input  logic                        nvdla_core_rst,
   nv_nvdla_cdma_wt_lock_arb_if.slave  arb
);

   if (IDX_W != clog2_f(NUM_REQ)) begin : g_bad_idx_w
      $error("IDX_W must equal clog2(NUM_REQ)");
   end
   if (MAX_BURST >= (1 << CNT_W)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for MAX_BURST");
   end

   localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

   arb_state_e         state, state_nxt;
   logic [IDX_W-1:0]   owner, owner_nxt;
   logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt, cnt_inc;
   logic [IDX_W-1:0]   pick_ptr, pick_idx, sel_idx;
   logic [NUM_REQ-1:0] pick_win;
   logic               sel_req, sel_last, accept;

   // Strict mode keeps the pointer at 0, so the picker is a plain
   // lowest-index priority encoder there.
   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
      if (RR_MODE == 0) return '0;
      return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
   endfunction

   assign pick_ptr = (RR_MODE != 0) ? rr_ptr : '0;

   nv_nvdla_cdma_wt_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req     (arb.req),
      .ptr     (pick_ptr),
      .win     (pick_win),
      .win_idx (pick_idx)
   );

   always_comb begin
      // While locked only the owner is eligible; other requests are ignored.
      sel_idx  = (state == ARB_LOCKED) ? owner : pick_idx;
      sel_req  = (state == ARB_LOCKED) ? arb.req[owner] : |pick_win;
      sel_last = arb.req_last[sel_idx];
      accept   = sel_req & ~arb.gnt_busy & ~nvdla_core_rst;
      cnt_inc  = beat_cnt + CNT_W'(1);

      arb.gnt     = '0;
      arb.gnt_idx = '0;
      if (accept) begin
         arb.gnt[sel_idx] = 1'b1;
         arb.gnt_idx      = sel_idx;
      end

      state_nxt    = state;
      owner_nxt    = owner;
      rr_ptr_nxt   = rr_ptr;
      beat_cnt_nxt = beat_cnt;

      // A stalled cycle freezes everything, including an abandon.
      if (!arb.gnt_busy) begin
         case (state)
            ARB_IDLE: begin
               if (accept) begin
                  if (sel_last || (MAX_BURST == 1)) begin
                     rr_ptr_nxt = next_ptr(sel_idx);
                  end else begin
                     state_nxt    = ARB_LOCKED;
                     owner_nxt    = sel_idx;
                     beat_cnt_nxt = CNT_W'(1);
                  end
               end
            end
            ARB_LOCKED: begin
               // Release on abandon, last beat or burst limit; the freed
               // slot is not re-arbitrated until the next cycle.
               if (!arb.req[owner] || sel_last || (cnt_inc == MAX_BURST_C)) begin
                  state_nxt    = ARB_IDLE;
                  beat_cnt_nxt = '0;
                  rr_ptr_nxt   = next_ptr(owner);
               end else begin
                  beat_cnt_nxt = cnt_inc;
               end
            end
            default: state_nxt = ARB_IDLE;
         endcase
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         state    <= ARB_IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         rr_ptr   <= rr_ptr_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   assign arb.arb_locked = (state == ARB_LOCKED);

endmodule

// File: tb/tb_nv_nvdla_cdma_wt_lock_arb.sv
// ---------------------------------------------------------------------------
// tb_nv_nvdla_cdma_wt_lock_arb
// Drives a strict-priority and a round-robin instance with identical
// stimulus and compares both against a behavioural model of the arbitration
// rules (lock owner, beat count, rotating pointer kept as plain integers).
// ---------------------------------------------------------------------------
module tb_nv_nvdla_cdma_wt_lock_arb;

   localparam int N    = 4;
   localparam int MAXB = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, req_last;
   logic       busy;

   always #5 clk = ~clk;

   nv_nvdla_cdma_wt_lock_arb_if #(.NUM_REQ(N), .IDX_W(2)) if_st ();
   nv_nvdla_cdma_wt_lock_arb_if #(.NUM_REQ(N), .IDX_W(2)) if_rr ();

   assign if_st.req      = req;
   assign if_st.req_last = req_last;
   assign if_st.gnt_busy = busy;
   assign if_rr.req      = req;
   assign if_rr.req_last = req_last;
   assign if_rr.gnt_busy = busy;

   nv_nvdla_cdma_wt_lock_arb #(
      .NUM_REQ(N), .IDX_W(2), .RR_MODE(0), .MAX_BURST(MAXB), .CNT_W(8)
   ) u_dut_st (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .arb            (if_st)
   );

   nv_nvdla_cdma_wt_lock_arb #(
      .NUM_REQ(N), .IDX_W(2), .RR_MODE(1), .MAX_BURST(MAXB), .CNT_W(8)
   ) u_dut_rr (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .arb            (if_rr)
   );

   logic [3:0] gnt_o [2];
   logic [1:0] idx_o [2];
   logic       lck_o [2];
   assign gnt_o[0] = if_st.gnt;
   assign gnt_o[1] = if_rr.gnt;
   assign idx_o[0] = if_st.gnt_idx;
   assign idx_o[1] = if_rr.gnt_idx;
   assign lck_o[0] = if_st.arb_locked;
   assign lck_o[1] = if_rr.arb_locked;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Model state, index 0 = strict instance, 1 = round-robin instance.
   int m_lock [2];
   int m_own  [2];
   int m_beat [2];
   int m_ptr  [2];

   function automatic bit bit_of(input logic [3:0] v, input int i);
      logic [3:0] t;
      t = v >> i;
      return t[0];
   endfunction

   function automatic int pick(input int m);
      int st;
      int i;
      st = (m == 1) ? m_ptr[m] : 0;
      for (int k = 0; k < N; k++) begin
         i = (st + k) % N;
         if (bit_of(req, i)) return i;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_gnt(input int m);
      int w;
      if (rst || busy) return 4'b0000;
      if (m_lock[m] != 0) return bit_of(req, m_own[m]) ? (4'b0001 << m_own[m]) : 4'b0000;
      w = pick(m);
      return (w < 0) ? 4'b0000 : (4'b0001 << w);
   endfunction

   function automatic logic [1:0] idx_of(input logic [3:0] g);
      for (int i = 0; i < N; i++) if (bit_of(g, i)) return 2'(i);
      return 2'd0;
   endfunction

   task automatic model_release(input int m);
      m_lock[m] = 0;
      m_beat[m] = 0;
      m_ptr[m]  = (m == 1) ? (m_own[m] + 1) % N : 0;
   endtask

   task automatic model_update(input int m);
      int w;
      if (rst) begin
         m_lock[m] = 0; m_own[m] = 0; m_beat[m] = 0; m_ptr[m] = 0;
         return;
      end
      if (busy) return;
      if (m_lock[m] == 0) begin
         w = pick(m);
         if (w < 0) return;
         if (bit_of(req_last, w) || MAXB == 1) begin
            m_ptr[m] = (m == 1) ? (w + 1) % N : 0;
         end else begin
            m_lock[m] = 1; m_own[m] = w; m_beat[m] = 1;
         end
      end else if (bit_of(req, m_own[m])) begin
         m_beat[m]++;
         if (bit_of(req_last, m_own[m]) || m_beat[m] == MAXB) model_release(m);
      end else begin
         model_release(m);
      end
   endtask

   // One cycle: drive at the falling edge, check, then advance the model to
   // match the coming rising edge.
   task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lst, input logic b);
      logic [3:0] eg;
      string      nm;
      @(negedge clk);
      rst = r; req = rq; req_last = lst; busy = b;
      #1;
      for (int m = 0; m < 2; m++) begin
         nm = (m == 1) ? "rr" : "st";
         eg = exp_gnt(m);
         chk({nm, "_gnt"}, 32'(gnt_o[m]), 32'(eg));
         chk({nm, "_idx"}, 32'(idx_o[m]), 32'(idx_of(eg)));
         chk({nm, "_locked"}, 32'(lck_o[m]), 32'(m_lock[m] != 0));
      end
      for (int m = 0; m < 2; m++) model_update(m);
   endtask

   logic [3:0] rr_seq [5];

   initial begin
      for (int m = 0; m < 2; m++) begin
         m_lock[m] = 0; m_own[m] = 0; m_beat[m] = 0; m_ptr[m] = 0;
      end
      rst = 1'b1; req = '0; req_last = '0; busy = 1'b0;
      repeat (2) @(posedge clk);

      // Reset holds grants off even with all requests up.
      for (int c = 0; c < 3; c++) begin
         step(1'b1, 4'b1111, 4'b0000, 1'b0);
         chk("rst_gnt_st", 32'(if_st.gnt), 32'd0);
         chk("rst_gnt_rr", 32'(if_rr.gnt), 32'd0);
         chk("rst_lck_rr", 32'(if_rr.arb_locked), 32'd0);
      end
      step(1'b0, 4'b1111, 4'b1111, 1'b0);
      chk("post_rst_st", 32'(if_st.gnt), 32'h1);
      chk("post_rst_rr", 32'(if_rr.gnt), 32'h1);

      // Strict priority always picks the lower index.
      step(1'b1, 4'b0000, 4'b0000, 1'b0);
      for (int c = 0; c < 4; c++) begin
         step(1'b0, 4'b1010, 4'b1010, 1'b0);
         chk("strict_1010", 32'(if_st.gnt), 32'h2);
      end

      // Round-robin rotation with single-beat bursts.
      step(1'b1, 4'b0000, 4'b0000, 1'b0);
      rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int c = 0; c < 5; c++) begin
         step(1'b0, 4'b1111, 4'b1111, 1'b0);
         chk("rr_rotate", 32'(if_rr.gnt), 32'(rr_seq[c]));
      end

      // Burst lock on requester 2 up to MAX_BURST, requester 0 blocked.
      step(1'b1, 4'b0000, 4'b0000, 1'b0);
      for (int c = 0; c < MAXB; c++) begin
         step(1'b0, (c < 2) ? 4'b0100 : 4'b0101, 4'b0000, 1'b0);
         chk("lock_st", 32'(if_st.gnt), 32'h4);
         chk("lock_rr", 32'(if_rr.gnt), 32'h4);
      end
      step(1'b0, 4'b1001, 4'b1001, 1'b0);
      chk("after_lock_rr", 32'(if_rr.gnt), 32'h8);
      chk("after_lock_st", 32'(if_st.gnt), 32'h1);
      chk("after_lock_lck", 32'(if_rr.arb_locked), 32'd0);
      step(1'b0, 4'b1001, 4'b1001, 1'b0);
      chk("after_lock2_rr", 32'(if_rr.gnt), 32'h1);

      // Busy stalls a locked burst without consuming beats.
      step(1'b1, 4'b0000, 4'b0000, 1'b0);
      for (int c = 0; c < 3; c++) step(1'b0, 4'b0010, 4'b0000, 1'b0);
      for (int c = 0; c < 5; c++) begin
         step(1'b0, 4'b0010, 4'b0000, 1'b1);
         chk("busy_gnt", 32'(if_rr.gnt), 32'd0);
         chk("busy_lck", 32'(if_rr.arb_locked), 32'd1);
      end
      for (int c = 0; c < 5; c++) begin
         step(1'b0, 4'b0010, 4'b0000, 1'b0);
         chk("busy_resume", 32'(if_st.gnt), 32'h2);
      end
      step(1'b0, 4'b0000, 4'b0000, 1'b0);
      chk("busy_release", 32'(if_st.arb_locked), 32'd0);

      // Abandon: owner drops its request, nobody else is granted that cycle.
      step(1'b1, 4'b0000, 4'b0000, 1'b0);
      for (int c = 0; c < 3; c++) step(1'b0, 4'b0100, 4'b0000, 1'b0);
      step(1'b0, 4'b1000, 4'b0000, 1'b0);
      chk("abandon_gnt", 32'(if_rr.gnt), 32'd0);
      step(1'b0, 4'b1000, 4'b1000, 1'b0);
      chk("abandon_next", 32'(if_rr.gnt), 32'h8);
      chk("abandon_lck", 32'(if_rr.arb_locked), 32'd0);

      // Randomised traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         step(($urandom_range(0, 199) == 0),
              4'($urandom) | 4'($urandom),
              4'($urandom) & 4'($urandom),
              ($urandom_range(0, 4) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
